uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Parametrised UART transmit channel and successor to the fixed 8N1 transmitter. It accepts bytes through a valid/ready handshake into an internal FIFO and serialises them LSB-first onto `sdata`. Data width, parity mode, stop-bit count, FIFO depth and baud rate are all configurable. It sits between a bus-side producer and the board TX pin, uses a single clock domain, and includes its own bit-period divider.

## Interface
- `DATA_BITS`, 8: payload bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 4: entries; must be a power of 2 and at least 2.
- `BAUDRATE`, 115200: line rate in bits per second.
- `CLOCK_INPUT`, 50_000_000: frequency of `clock` in Hz.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `valid` in 1: producer offers `data` this cycle.
- `data` in DATA_BITS: payload, sampled when `valid && ready`.
- `ready` out 1: FIFO can accept a word; combinational, `fifo_level != FIFO_DEPTH`.
- `sdata` out 1: serial line, registered; idles high.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `tx_done` out 1: one-cycle pulse in the cycle after the last stop bit completes.
- `fifo_level` out $clog2(FIFO_DEPTH+1): number of words currently queued.

## Operation
- `DIV = CLOCK_INPUT / BAUDRATE`, truncated. `DIV < 2` or any illegal parameter value is an elaboration error.
- Every line bit lasts exactly DIV clock cycles. The bit counter is $clog2(DIV) bits wide and restarts at each bit boundary.
- Frame on the line: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS bits of 1.
- Parity is computed over the DATA_BITS payload bits. Even: XOR of the bits. Odd: inverted XOR.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty, pop, load the shift register and latch parity, then go to START. Otherwise stay.
  - START → DATA after DIV cycles.
  - DATA holds DATA_BITS × DIV cycles, shifting one bit every DIV cycles. It then goes to PARITY if `PARITY != 0`, else STOP.
  - PARITY → STOP after DIV cycles.
  - STOP holds STOP_BITS × DIV cycles. On exit it pulses `tx_done`.
    - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE.
- FIFO push happens on `valid && ready`. Data is written at the write pointer and pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop with `0 < fifo_level < FIFO_DEPTH`: level stays the same and both operations take effect.
- Full FIFO with a pop in the same cycle: `ready` is low, so the push is refused. `ready` rises the following cycle.
- `valid` while `ready` is low is ignored. The producer must hold `data` until accepted.
- `data` bits are not required to be stable when `valid` is low.

## Timing
- Reset values: `sdata`=1, `busy`=0, `tx_done`=0, `fifo_level`=0, `ready`=1, FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-frame:
  - `sdata` returns to 1 asynchronously.
  - Queued words are discarded.
  - No `tx_done` pulse is issued.
- Latency from idle with an empty FIFO, push accepted at edge k:
  - `fifo_level`=1 after edge k.
  - Pop, START, `busy`=1 and `sdata`=0 after edge k+1.
  - `fifo_level` returns to 0 after edge k+1.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIV cycles, measured from the `sdata` falling edge to the next start bit in back-to-back mode.
- `tx_done` is high for exactly one cycle, coincident with either the first START cycle of the next frame or the first IDLE cycle.
- `busy` falls in the same cycle `tx_done` is high only if the FIFO is empty.

## Test plan
- Reset check: reset asserted for 3 cycles with `valid`=1 → `sdata`=1, `ready`=1, `fifo_level`=0, `busy`=0; no push accepted.
- 8E1 frame (CLOCK_INPUT=1_000_000, BAUDRATE=100_000, so DIV=10), push 0xA5 → `sdata` reads 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 10 cycles. `tx_done` pulses 110 cycles after the start edge.
- 8O2 frame with the same DIV, push 0xA5 → parity bit 1, stop high for 20 cycles, frame 120 cycles. 7N1 frame, push 0x7F → frame 90 cycles with no parity bit.
- Back-to-back traffic: push 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames with no idle gap, three `tx_done` pulses spaced 100 cycles apart (8N1), and `busy` held high throughout.
- FIFO full (FIFO_DEPTH=4): push 6 words in a burst → 5 accepted (1 popped immediately, 4 queued); `ready`=0 until the next pop, when it rises the cycle after. All 5 words transmitted in order; the rejected word never appears.
- Reset mid-frame: assert `reset` during the 3rd data bit → `sdata`=1 immediately, FIFO empty, and a frame pushed after release transmits correctly.

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmit channel with a valid/ready input FIFO,
// configurable data width, parity, stop bits and an internal baud divider.
module uart_tx_framer #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BAUDRATE    = 115200,
  parameter int unsigned CLOCK_INPUT = 50_000_000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               valid,
  input  logic [DATA_BITS-1:0]               data,
  output logic                               ready,
  output logic                               sdata,
  output logic                               busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned DIV = CLOCK_INPUT / BAUDRATE;
  localparam int unsigned CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (FIFO_DEPTH >= 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_framer: CLOCK_INPUT / BAUDRATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_framer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [IW-1:0]        bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_nx;
  logic                 sdata_nx, done_nx, tick;

  assign ready      = (fifo_level != LVL_FULL);
  assign push       = valid && ready;
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 2) ? ~^head : ^head;
  assign tick       = (cnt == CNT_LAST);
  assign busy       = (state != S_IDLE);

  // FIFO storage write port
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Transmit FSM state, bit timing and registered line output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      sdata   <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      par_bit <= par_nx;
      sdata   <= sdata_nx;
      tx_done <= done_nx;
    end
  end

  // Next-state logic; sdata is derived from the next state so the line
  // changes on the same edge the FSM enters a new bit.
  always_comb begin
    state_nx   = state;
    cnt_nx     = '0;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    pop        = 1'b0;
    done_nx    = 1'b0;
    sdata_nx   = 1'b1;
    if (state != S_IDLE) cnt_nx = tick ? '0 : cnt + CW'(1);
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          par_nx   = head_par;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          bit_idx_nx = '0;
          state_nx   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx == DATA_LAST) begin
            bit_idx_nx = '0;
            state_nx   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nx = bit_idx + IW'(1);
            shreg_nx   = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          bit_idx_nx = '0;
          state_nx   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_idx == STOP_LAST) begin
            done_nx    = 1'b1;
            bit_idx_nx = '0;
            if (!fifo_empty) begin
              pop      = 1'b1;
              shreg_nx = head;
              par_nx   = head_par;
              state_nx = S_START;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            bit_idx_nx = bit_idx + IW'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    case (state_nx)
      S_START:  sdata_nx = 1'b0;
      S_DATA:   sdata_nx = shreg_nx[0];
      S_PARITY: sdata_nx = par_nx;
      default:  sdata_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed checks of uart_tx_framer in 8E1, 8O2, 7N1 and
// 8N1 configurations, all with a divider of 10 clocks per bit.
module tb_uart_tx_framer;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  // Edge counter: at a falling edge, cyc equals the number of rising edges seen.
  always @(posedge clock) cyc <= cyc + 1;

  logic       v0, v1, v2, v3;
  logic [7:0] d0, d1, d3;
  logic [6:0] d2;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       sd0, sd1, sd2, sd3;
  logic       bsy0, bsy1, bsy2, bsy3;
  logic       dn0, dn1, dn2, dn3;
  logic [2:0] lv0, lv1, lv2, lv3;

  int done_q[$];

  always @(negedge clock) if (dn3 === 1'b1) done_q.push_back(cyc);

  uart_tx_framer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4),
                   .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000)) u_8e1 (
    .clock(clock), .reset(reset), .valid(v0), .data(d0), .ready(rdy0),
    .sdata(sd0), .busy(bsy0), .tx_done(dn0), .fifo_level(lv0));

  uart_tx_framer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4),
                   .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000)) u_8o2 (
    .clock(clock), .reset(reset), .valid(v1), .data(d1), .ready(rdy1),
    .sdata(sd1), .busy(bsy1), .tx_done(dn1), .fifo_level(lv1));

  uart_tx_framer #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4),
                   .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000)) u_7n1 (
    .clock(clock), .reset(reset), .valid(v2), .data(d2), .ready(rdy2),
    .sdata(sd2), .busy(bsy2), .tx_done(dn2), .fifo_level(lv2));

  uart_tx_framer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4),
                   .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000)) u_8n1 (
    .clock(clock), .reset(reset), .valid(v3), .data(d3), .ready(rdy3),
    .sdata(sd3), .busy(bsy3), .tx_done(dn3), .fifo_level(lv3));

  function automatic logic get_sd(input int d);
    case (d) 0: return sd0; 1: return sd1; 2: return sd2; default: return sd3; endcase
  endfunction
  function automatic logic get_busy(input int d);
    case (d) 0: return bsy0; 1: return bsy1; 2: return bsy2; default: return bsy3; endcase
  endfunction
  function automatic logic get_done(input int d);
    case (d) 0: return dn0; 1: return dn1; 2: return dn2; default: return dn3; endcase
  endfunction
  function automatic logic get_rdy(input int d);
    case (d) 0: return rdy0; 1: return rdy1; 2: return rdy2; default: return rdy3; endcase
  endfunction
  function automatic logic [2:0] get_lvl(input int d);
    case (d) 0: return lv0; 1: return lv1; 2: return lv2; default: return lv3; endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [8:0] w);
    case (d)
      0:       begin v0 = v; d0 = w[7:0]; end
      1:       begin v1 = v; d1 = w[7:0]; end
      2:       begin v2 = v; d2 = w[6:0]; end
      default: begin v3 = v; d3 = w[7:0]; end
    endcase
  endtask

  task automatic push_one(input int d, input logic [8:0] w);
    @(negedge clock);
    drive(d, 1'b1, w);
    @(posedge clock);
    #1;
    drive(d, 1'b0, w);
  endtask

  // Waits for a 1->0 transition on the selected line, then records the line
  // level in the first (f) and last (l) cycle of each of nb bits.
  task automatic capture(input int d, input int nb, output logic [15:0] f,
                         output logic [15:0] l, output int s,
                         output logic busy_all, output logic to);
    logic prev;
    int   w;
    f = '0; l = '0; s = -1; busy_all = 1'b1; to = 1'b0;
    prev = get_sd(d);
    w = 0;
    forever begin
      @(negedge clock);
      if (prev === 1'b1 && get_sd(d) === 1'b0) break;
      prev = get_sd(d);
      w++;
      if (w >= 400) begin
        to = 1'b1;
        return;
      end
    end
    s = cyc;
    for (int k = 0; k < nb * 10; k++) begin
      if (k > 0) @(negedge clock);
      if (k % 10 == 0) f[k / 10] = get_sd(d);
      if (k % 10 == 9) l[k / 10] = get_sd(d);
      busy_all = busy_all & get_busy(d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 4; d++) drive(d, 1'b1, 9'h055);
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      checks++; if (get_sd(d) !== 1'b1) begin errors++; $display("FAIL reset_sdata dut%0d got=%b exp=1", d, get_sd(d)); end
      checks++; if (get_rdy(d) !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got=%b exp=1", d, get_rdy(d)); end
      checks++; if (get_lvl(d) !== 3'd0) begin errors++; $display("FAIL reset_level dut%0d got=%0d exp=0", d, get_lvl(d)); end
      checks++; if (get_busy(d) !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, get_busy(d)); end
      checks++; if (get_done(d) !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got=%b exp=0", d, get_done(d)); end
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 9'h000);
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      checks++; if (get_lvl(d) !== 3'd0 || get_busy(d) !== 1'b0) begin
        errors++; $display("FAIL reset_no_push dut%0d got level=%0d busy=%b exp level=0 busy=0", d, get_lvl(d), get_busy(d));
      end
    end
  endtask

  // Single frame on dut d: exp holds the line bits, start bit in bit 0.
  task automatic test_frame(input string name, input int d, input logic [8:0] w,
                            input int nb, input logic [15:0] exp, input int flen);
    logic [15:0] f, l;
    int          s;
    logic        b, to;
    push_one(d, w);
    capture(d, nb, f, l, s, b, to);
    checks++; if (to) begin errors++; $display("FAIL %s_start got=timeout exp=start bit", name); end
    checks++; if (f !== exp) begin errors++; $display("FAIL %s_bits_first got=%h exp=%h", name, f, exp); end
    checks++; if (l !== exp) begin errors++; $display("FAIL %s_bits_last got=%h exp=%h", name, l, exp); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, b); end
    @(negedge clock);
    checks++; if (get_done(d) !== 1'b1 || (cyc - s) !== flen) begin
      errors++; $display("FAIL %s_tx_done got done=%b at %0d exp done=1 at %0d", name, get_done(d), cyc - s, flen);
    end
    checks++; if (get_busy(d) !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", name, get_busy(d)); end
    @(negedge clock);
    checks++; if (get_done(d) !== 1'b0) begin errors++; $display("FAIL %s_done_width got=%b exp=0", name, get_done(d)); end
  endtask

  task automatic test_8e1();
    test_frame("8e1", 0, 9'h0A5, 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 110);
  endtask

  task automatic test_8o2();
    test_frame("8o2", 1, 9'h0A5, 12, {4'b0, 2'b11, 1'b1, 8'hA5, 1'b0}, 120);
  endtask

  task automatic test_7n1();
    test_frame("7n1", 2, 9'h07F, 9, {7'b0, 1'b1, 7'h7F, 1'b0}, 90);
  endtask

  task automatic test_back_to_back();
    logic [15:0] f[3], l[3];
    int          s[3];
    logic        b[3], to[3];
    done_q.delete();
    fork
      begin
        @(negedge clock); drive(3, 1'b1, 9'h001);
        @(negedge clock); drive(3, 1'b1, 9'h002);
        @(negedge clock); drive(3, 1'b1, 9'h003);
        @(negedge clock); drive(3, 1'b0, 9'h000);
      end
      for (int i = 0; i < 3; i++) capture(3, 10, f[i], l[i], s[i], b[i], to[i]);
    join
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp;
      exp = {6'b0, 1'b1, 8'(i + 1), 1'b0};
      checks++; if (to[i] || f[i] !== exp || l[i] !== exp) begin
        errors++; $display("FAIL b2b_frame%0d got first=%h last=%h to=%b exp=%h", i, f[i], l[i], to[i], exp);
      end
      checks++; if (b[i] !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d got=%b exp=1", i, b[i]); end
    end
    checks++; if (s[1] - s[0] !== 100 || s[2] - s[1] !== 100) begin
      errors++; $display("FAIL b2b_gap got=%0d,%0d exp=100,100", s[1] - s[0], s[2] - s[1]);
    end
    @(negedge clock);
    checks++; if (dn3 !== 1'b1 || bsy3 !== 1'b0) begin
      errors++; $display("FAIL b2b_last_done got done=%b busy=%b exp done=1 busy=0", dn3, bsy3);
    end
    @(negedge clock);
    checks++; if (done_q.size() !== 3) begin
      errors++; $display("FAIL b2b_done_count got=%0d exp=3", done_q.size());
    end else begin
      checks++; if (done_q[0] - s[0] !== 100 || done_q[1] - s[0] !== 200 || done_q[2] - s[0] !== 300) begin
        errors++; $display("FAIL b2b_done_times got=%0d,%0d,%0d exp=100,200,300", done_q[0] - s[0], done_q[1] - s[0], done_q[2] - s[0]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0]  words[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [15:0] f[5], l[5];
    int          s[5];
    logic        b[5], to[5];
    int          acc = 0;
    logic [5:0]  acc_mask = '0;
    int          pk = 0;
    int          quiet = 0;
    fork
      begin
        int w;
        for (int i = 0; i < 6; i++) begin
          @(negedge clock);
          drive(3, 1'b1, {1'b0, words[i]});
          if (i == 0) pk = cyc + 1;
          if (rdy3 === 1'b1) begin acc++; acc_mask[i] = 1'b1; end
        end
        @(negedge clock);
        drive(3, 1'b0, 9'h000);
        checks++; if (acc !== 5 || acc_mask !== 6'b011111) begin
          errors++; $display("FAIL full_accepted got=%0d mask=%b exp=5 mask=011111", acc, acc_mask);
        end
        checks++; if (lv3 !== 3'd4 || rdy3 !== 1'b0) begin
          errors++; $display("FAIL full_level got level=%0d ready=%b exp level=4 ready=0", lv3, rdy3);
        end
        w = 0;
        while (rdy3 !== 1'b1 && w < 300) begin @(negedge clock); w++; end
        checks++; if (w >= 300 || cyc !== pk + 101 || dn3 !== 1'b1) begin
          errors++; $display("FAIL full_ready_rise got at %0d done=%b exp at %0d done=1", cyc - pk, dn3, 101);
        end
      end
      begin
        for (int i = 0; i < 5; i++) capture(3, 10, f[i], l[i], s[i], b[i], to[i]);
        for (int k = 0; k < 200; k++) begin
          @(negedge clock);
          if (sd3 !== 1'b1) quiet++;
        end
      end
    join
    for (int i = 0; i < 5; i++) begin
      logic [15:0] exp;
      exp = {6'b0, 1'b1, words[i], 1'b0};
      checks++; if (to[i] || f[i] !== exp || l[i] !== exp) begin
        errors++; $display("FAIL full_frame%0d got first=%h last=%h to=%b exp=%h", i, f[i], l[i], to[i], exp);
      end
    end
    checks++; if (quiet !== 0) begin
      errors++; $display("FAIL full_rejected_word got=%0d low cycles exp=0", quiet);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] f, l;
    int          s, st;
    logic        b, to;
    int          bad = 0;
    @(negedge clock); drive(3, 1'b1, 9'h0C3);
    st = cyc + 2;
    @(negedge clock); drive(3, 1'b1, 9'h05A);
    @(negedge clock); drive(3, 1'b1, 9'h066);
    @(negedge clock); drive(3, 1'b0, 9'h000);
    while (cyc < st + 35) @(negedge clock);
    checks++; if (sd3 !== 1'b0 || lv3 !== 3'd2) begin
      errors++; $display("FAIL mid_pre got sdata=%b level=%0d exp sdata=0 level=2", sd3, lv3);
    end
    done_q.delete();
    #2 reset = 1'b1;
    #1;
    checks++; if (sd3 !== 1'b1) begin errors++; $display("FAIL mid_async_sdata got=%b exp=1", sd3); end
    checks++; if (lv3 !== 3'd0 || rdy3 !== 1'b1 || bsy3 !== 1'b0 || dn3 !== 1'b0) begin
      errors++; $display("FAIL mid_async_state got level=%0d ready=%b busy=%b done=%b exp 0,1,0,0", lv3, rdy3, bsy3, dn3);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clock);
      if (sd3 !== 1'b1 || bsy3 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || done_q.size() !== 0) begin
      errors++; $display("FAIL mid_discard got bad=%0d dones=%0d exp 0,0", bad, done_q.size());
    end
    push_one(3, 9'h096);
    capture(3, 10, f, l, s, b, to);
    checks++; if (to || f !== {6'b0, 1'b1, 8'h96, 1'b0} || l !== {6'b0, 1'b1, 8'h96, 1'b0}) begin
      errors++; $display("FAIL mid_after got first=%h last=%h to=%b exp=%h", f, l, to, {6'b0, 1'b1, 8'h96, 1'b0});
    end
    @(negedge clock);
    checks++; if (dn3 !== 1'b1 || cyc - s !== 100) begin
      errors++; $display("FAIL mid_after_done got done=%b at %0d exp done=1 at 100", dn3, cyc - s);
    end
  endtask

  initial begin
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    test_reset();
    test_8e1();
    test_8o2();
    test_7n1();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
